// File: rtl/note_sample_streamer.sv
// Streams a stored note's PCM bytes from sample memory through a prefetch FIFO, one byte per sample tick.
// Optional macro NOTE_LOOP_EN: held notes wrap to byte 0 instead of stopping at the end of the note.
module note_sample_streamer #(
    parameter int                 ADDR_W     = 24,
    parameter int                 DATA_W     = 8,
    parameter int                 NOTE_LEN   = 11264,
    parameter int                 FIFO_DEPTH = 16,
    parameter logic [ADDR_W-1:0]  REST_ADDR  = 24'h002C00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] note_addr,
    input  logic              sample_tick,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              playing,
    output logic              underrun
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam int                OFF_W    = 14;
    localparam logic [DATA_W-1:0] SILENCE  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(NOTE_LEN - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [OFF_W-1:0]  offset;
    logic              fetch_done;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count, count_nxt;
    logic              note_change, push, pop;

    assign note_change = (note_addr != base);
    assign push        = (state == WAIT) && mem_rvalid && !note_change;
    assign pop         = sample_tick && !note_change && (fifo_count != '0);
    assign mem_req     = (state == REQ);

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop)
            count_nxt = fifo_count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = fifo_count - CNT_W'(1);
    end

    // A note change abandons the current fetch; an accepted read must still be drained in DROP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!note_change && playing && !fetch_done && (fifo_count < DEPTH_C))
                      state_nxt = REQ;
            REQ:  if (note_change)   state_nxt = mem_ready ? DROP : IDLE;
                  else if (mem_ready) state_nxt = WAIT;
            WAIT: if (note_change)   state_nxt = mem_rvalid ? IDLE : DROP;
                  else if (mem_rvalid) state_nxt = IDLE;
            DROP: if (mem_rvalid)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state != REQ && state_nxt == REQ)
                mem_addr <= base + ADDR_W'(offset);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base       <= REST_ADDR;
            offset     <= '0;
            fetch_done <= 1'b0;
            playing    <= 1'b0;
        end else if (note_change) begin
            base       <= note_addr;
            offset     <= '0;
            fetch_done <= 1'b0;
            playing    <= (note_addr != REST_ADDR);
        end else begin
            if (push) begin
                if (offset == LAST_OFF) begin
`ifdef NOTE_LOOP_EN
                    offset <= '0;
`else
                    fetch_done <= 1'b1;
`endif
                end else begin
                    offset <= offset + OFF_W'(1);
                end
            end
            // Drop playing on the cycle the last fetched byte leaves, so no spurious underrun follows.
            if (fetch_done && count_nxt == '0)
                playing <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (note_change) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out   <= SILENCE;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= sample_tick;
            underrun     <= 1'b0;
            if (sample_tick) begin
                if (pop) begin
                    sample_out <= fifo_mem[rd_ptr];
                end else begin
                    sample_out <= SILENCE;
                    underrun   <= playing && !note_change;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_sample_streamer.sv
// Directed bench for note_sample_streamer with a fixed-latency memory responder returning addr[7:0].
module tb_note_sample_streamer;

    localparam logic [23:0] REST = 24'h002C00;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] note_addr = REST;
    logic        sample_tick = 1'b0;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        playing;
    logic        underrun;

    logic        ready_en = 1'b0;
    int          lat_cnt = 0;
    logic [23:0] pend_addr = '0;
    int          n_accept = 0;
    int          passed = 0;
    int          total = 0;

    assign mem_ready = ready_en;

    note_sample_streamer dut (
        .clk(clk), .rst_n(rst_n), .note_addr(note_addr), .sample_tick(sample_tick),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .sample_out(sample_out),
        .sample_valid(sample_valid), .playing(playing), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Memory responder: a request seen here is accepted at the next rising edge; data follows LAT cycles later.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_addr[7:0];
            end
        end
        if (mem_req && ready_en) begin
            pend_addr = mem_addr;
            lat_cnt   = LAT;
            n_accept  = n_accept + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int maxc);
        for (int i = 0; i < maxc && !mem_req; i++) cyc(1);
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    int          acc0;
    logic        last_req, seen_last, found;
    logic [23:0] next_addr;
    int          post;

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        cyc(2);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_sample_out", 32'(sample_out), 32'h80);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Tick on the rest note: silence, no underrun
        tick();
        chk("rest_out", 32'(sample_out), 32'h80);
        chk("rest_valid", 32'(sample_valid), 32'd1);
        chk("rest_underrun", 32'(underrun), 32'd0);
        cyc(1);
        chk("valid_one_cycle", 32'(sample_valid), 32'd0);

        // Start note 0x005800 and fill the FIFO without ticks
        ready_en  = 1'b1;
        acc0      = n_accept;
        note_addr = 24'h005800;
        wait_req("first_req", 10);
        chk("first_addr", 32'(mem_addr), 32'h005800);
        chk("playing_on", 32'(playing), 32'd1);
        cyc(100);
        chk("fill_reads", 32'(n_accept - acc0), 32'd16);
        chk("fill_req_idle", 32'(mem_req), 32'd0);
        tick();
        chk("byte0", 32'(sample_out), 32'h00);
        chk("byte0_valid", 32'(sample_valid), 32'd1);
        cyc(20);
        chk("refill_one", 32'(n_accept - acc0), 32'd17);
        tick();
        chk("byte1", 32'(sample_out), 32'h01);
        tick();
        chk("byte2", 32'(sample_out), 32'h02);
        tick();
        chk("byte3", 32'(sample_out), 32'h03);
        cyc(30);

        // Note change while a read is in WAIT, with a tick in the same cycle
        tick();
        chk("byte4", 32'(sample_out), 32'h04);
        wait_req("wait_req5800", 10);
        cyc(1);
        note_addr   = 24'h008400;
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        chk("flush_out", 32'(sample_out), 32'h80);
        chk("flush_valid", 32'(sample_valid), 32'd1);
        chk("flush_underrun", 32'(underrun), 32'd0);
        wait_req("req8400", 20);
        chk("addr8400", 32'(mem_addr), 32'h008400);
        cyc(40);
        tick();
        chk("new_byte0", 32'(sample_out), 32'h00);
        tick();
        chk("new_byte1", 32'(sample_out), 32'h01);

        // Memory stalled: underrun on an empty FIFO
        ready_en = 1'b0;
        cyc(10);
        note_addr = 24'h00A000;
        cyc(1);
        wait_req("stall_req", 10);
        chk("stall_addr", 32'(mem_addr), 32'h00A000);
        tick();
        chk("stall_out", 32'(sample_out), 32'h80);
        chk("stall_valid", 32'(sample_valid), 32'd1);
        chk("stall_underrun", 32'(underrun), 32'd1);
        cyc(1);
        chk("underrun_pulse", 32'(underrun), 32'd0);
        chk("stall_req_held", 32'(mem_req), 32'd1);

        // Rest note while the request is still unaccepted
        note_addr = REST;
        cyc(1);
        chk("rest_req_drop", 32'(mem_req), 32'd0);
        chk("rest_playing", 32'(playing), 32'd0);
        tick();
        chk("rest2_out", 32'(sample_out), 32'h80);
        chk("rest2_underrun", 32'(underrun), 32'd0);

        // Reset while a read is in WAIT; its data arrives after reset
        ready_en  = 1'b1;
        note_addr = 24'h005800;
        cyc(20);
        wait_req("pre_rst_req", 10);
        cyc(1);
        rst_n     = 1'b0;
        note_addr = REST;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_out", 32'(sample_out), 32'h80);
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_playing", 32'(playing), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4);
        chk("post_rst_req", 32'(mem_req), 32'd0);
        tick();
        chk("post_rst_out", 32'(sample_out), 32'h80);
        chk("post_rst_underrun", 32'(underrun), 32'd0);

        // End of note at base+11263
        note_addr = 24'h00C000;
        last_req  = 1'b0;
        seen_last = 1'b0;
        found     = 1'b0;
        next_addr = '0;
        post      = 0;
        for (int c = 0; c < 52000 && !found && post < 200; c++) begin
            sample_tick = (c % 2) == 1;
            cyc(1);
            if (mem_req && !last_req) begin
                if (seen_last) begin
                    found     = 1'b1;
                    next_addr = mem_addr;
                end else if (mem_addr == 24'h00C000 + 24'd11263) begin
                    seen_last = 1'b1;
                end
            end
            if (seen_last) post++;
            last_req = mem_req;
        end
        sample_tick = 1'b0;
        chk("end_reached", 32'(seen_last), 32'd1);
`ifdef NOTE_LOOP_EN
        chk("loop_wrap_seen", 32'(found), 32'd1);
        chk("loop_wrap_addr", 32'(next_addr), 32'h00C000);
`else
        chk("end_no_req", 32'(found), 32'd0);
        chk("end_req_idle", 32'(mem_req), 32'd0);
        chk("end_playing", 32'(playing), 32'd0);
        tick();
        chk("end_out", 32'(sample_out), 32'h80);
        chk("end_valid", 32'(sample_valid), 32'd1);
        chk("end_underrun", 32'(underrun), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
